// File: rtl/factorial_seq_ctrl_if.sv
// Handshake and register-file bus between the factorial sequencer and its
// environment (start/result side plus the 4x32 regfile ports).
interface factorial_seq_ctrl_if #(
   parameter int N_W = 5
);
   logic           start;
   logic [N_W-1:0] n_in;
   logic           busy;
   logic           done;
   logic [31:0]    result;
   logic           overflow;

   logic           rf_we;
   logic [1:0]     rf_ra1;
   logic [1:0]     rf_ra2;
   logic [1:0]     rf_wa;
   logic [31:0]    rf_wd;
   logic [31:0]    rf_rd1;
   logic [31:0]    rf_rd2;

   modport slave (
      input  start, n_in, rf_rd1, rf_rd2,
      output busy, done, result, overflow,
      output rf_we, rf_ra1, rf_ra2, rf_wa, rf_wd
   );

   modport master (
      output start, n_in, rf_rd1, rf_rd2,
      input  busy, done, result, overflow,
      input  rf_we, rf_ra1, rf_ra2, rf_wa, rf_wd
   );
endinterface

// File: rtl/factorial_seq_ctrl.sv
// Computes n! mod 2^32 using an external 4x32 regfile as working storage
// (R0 = down-counter, R1 = accumulator) and an internal shift-add multiplier.
module factorial_seq_ctrl #(
   parameter int N_W     = 5,
   parameter int MUL_CYC = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   factorial_seq_ctrl_if.slave  bus
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INIT_N   = 3'd1;
   localparam logic [2:0] S_INIT_ACC = 3'd2;
   localparam logic [2:0] S_CHECK    = 3'd3;
   localparam logic [2:0] S_MUL      = 3'd4;
   localparam logic [2:0] S_WB       = 3'd5;
   localparam logic [2:0] S_DEC      = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   localparam int              CNT_W    = $clog2(MUL_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYC - 1);

   logic [2:0]       state;
   logic [N_W-1:0]   n_reg;
   logic [31:0]      result_q;
   logic             overflow_q;
   logic [63:0]      mcand;
   logic [31:0]      mplier;
   logic [63:0]      product;
   logic [CNT_W-1:0] mul_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         n_reg      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         mcand      <= '0;
         mplier     <= '0;
         product    <= '0;
         mul_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  n_reg      <= bus.n_in;
                  overflow_q <= 1'b0;
                  state      <= S_INIT_N;
               end
            end
            S_INIT_N:   state <= S_INIT_ACC;
            S_INIT_ACC: state <= S_CHECK;
            // R0 is the remaining multiplier; the run ends once it reaches 0 or 1
            S_CHECK: begin
               if (bus.rf_rd1 <= 32'd1) begin
                  result_q <= bus.rf_rd2;
                  state    <= S_DONE;
               end else begin
                  mcand   <= {32'd0, bus.rf_rd2};
                  mplier  <= bus.rf_rd1;
                  product <= '0;
                  mul_cnt <= '0;
                  state   <= S_MUL;
               end
            end
            S_MUL: begin
               if (mplier[0]) begin
                  product <= product + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (mul_cnt == CNT_LAST) begin
                  mul_cnt <= '0;
                  state   <= S_WB;
               end else begin
                  mul_cnt <= mul_cnt + 1'b1;
               end
            end
            S_WB: begin
               overflow_q <= overflow_q | (|product[63:32]);
               state      <= S_DEC;
            end
            S_DEC:   state <= S_CHECK;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Regfile writes are decoded straight from the state so reset clears them at once
   always_comb begin
      bus.rf_we = 1'b0;
      bus.rf_wa = 2'd0;
      bus.rf_wd = 32'd0;
      case (state)
         S_INIT_N: begin
            bus.rf_we = 1'b1;
            bus.rf_wa = 2'd0;
            bus.rf_wd = 32'(n_reg);
         end
         S_INIT_ACC: begin
            bus.rf_we = 1'b1;
            bus.rf_wa = 2'd1;
            bus.rf_wd = 32'd1;
         end
         S_WB: begin
            bus.rf_we = 1'b1;
            bus.rf_wa = 2'd1;
            bus.rf_wd = product[31:0];
         end
         S_DEC: begin
            bus.rf_we = 1'b1;
            bus.rf_wa = 2'd0;
            bus.rf_wd = bus.rf_rd1 - 32'd1;
         end
         default: begin
         end
      endcase
   end

   assign bus.rf_ra1   = 2'd0;
   assign bus.rf_ra2   = 2'd1;
   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.result   = result_q;
   assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Self-checking bench for factorial_seq_ctrl: behavioural regfile, factorial
// scoreboard with latency, write-trace and back-to-back checks.
module tb_factorial_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   factorial_seq_ctrl_if #(.N_W(5)) bus ();

   factorial_seq_ctrl #(.N_W(5), .MUL_CYC(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] rf_mem [4];
   always @(posedge clk) begin
      if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
   end
   assign bus.rf_rd1 = rf_mem[bus.rf_ra1];
   assign bus.rf_rd2 = rf_mem[bus.rf_ra2];

   typedef struct {
      logic [31:0] result;
      logic        ovf;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [33:0] wr_obs[$];
   bit          trace_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always @(negedge clk) begin
      if (trace_en && bus.rf_we === 1'b1) wr_obs.push_back({bus.rf_wa, bus.rf_wd});
   end

   function automatic exp_t model(input int n);
      exp_t        e;
      logic [31:0] acc;
      logic [63:0] p;
      acc   = 32'd1;
      e.ovf = 1'b0;
      for (int k = n; k >= 2; k--) begin
         p = 64'(acc) * 64'(k);
         if (p[63:32] != 32'd0) e.ovf = 1'b1;
         acc = p[31:0];
      end
      e.result = acc;
      e.lat    = (n <= 1) ? 4 : 4 + 35 * (n - 1);
      return e;
   endfunction

   // Called at a negedge while the DUT is idle; returns at the negedge of cycle 1
   task automatic start_run(input int n, input bit hold);
      bus.start = 1'b1;
      bus.n_in  = 5'(n);
      sb.push_back(model(n));
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int lat, output bit timeout);
      lat     = 0;
      timeout = 1'b1;
      for (int k = 1; k <= limit; k++) begin
         if (bus.done === 1'b1) begin
            lat     = k;
            timeout = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.n_in  = '0;
      #12;
      checks++;
      if ({bus.busy, bus.done, bus.rf_we, bus.overflow} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags got busy/done/we/ovf=%b expected 0000",
                  {bus.busy, bus.done, bus.rf_we, bus.overflow});
      end
      checks++;
      if (bus.result !== 32'd0 || bus.rf_wd !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_data got result=%h wd=%h expected 0/0", bus.result, bus.rf_wd);
      end
      checks++;
      if ({bus.rf_ra1, bus.rf_ra2, bus.rf_wa} !== 6'b00_01_00) begin
         errors++;
         $display("[TB] FAIL reset_addr got ra1/ra2/wa=%b expected 000100",
                  {bus.rf_ra1, bus.rf_ra2, bus.rf_wa});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int   lat;
      bit   to;
      exp_t e;
      start_run(3, 1'b0);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.rf_we} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL async_reset got busy/done/we=%b expected 000",
                  {bus.busy, bus.done, bus.rf_we});
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_run(3, 1'b0);
      wait_done(600, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || bus.result !== e.result) begin
         errors++;
         $display("[TB] FAIL after_reset_n3 got result=%0d timeout=%0d expected %0d", bus.result, to, e.result);
      end
      @(negedge clk);
   endtask

   task automatic test_small_n();
      int   lat;
      bit   to;
      exp_t e;
      for (int n = 0; n <= 1; n++) begin
         start_run(n, 1'b0);
         wait_done(600, lat, to);
         e = sb.pop_front();
         checks++;
         if (to || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL small_lat n=%0d got %0d (timeout=%0d) expected %0d", n, lat, to, e.lat);
         end
         checks++;
         if (bus.result !== e.result || bus.overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL small_res n=%0d got %0d/%b expected %0d/%b",
                     n, bus.result, bus.overflow, e.result, e.ovf);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_trace_n5();
      int          lat;
      bit          to;
      exp_t        e;
      logic [33:0] wr_exp[$];
      logic [31:0] acc;
      wr_obs.delete();
      trace_en = 1'b1;
      start_run(5, 1'b0);
      wait_done(600, lat, to);
      trace_en = 1'b0;
      e = sb.pop_front();
      checks++;
      if (to || lat !== e.lat) begin
         errors++;
         $display("[TB] FAIL n5_lat got %0d (timeout=%0d) expected %0d", lat, to, e.lat);
      end
      checks++;
      if (bus.result !== 32'h78 || bus.overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL n5_res got %h/%b expected 00000078/0", bus.result, bus.overflow);
      end
      wr_exp.push_back({2'd0, 32'd5});
      wr_exp.push_back({2'd1, 32'd1});
      acc = 32'd1;
      for (int k = 5; k >= 2; k--) begin
         acc = acc * 32'(k);
         wr_exp.push_back({2'd1, acc});
         wr_exp.push_back({2'd0, 32'(k - 1)});
      end
      checks++;
      if (wr_obs.size() != wr_exp.size()) begin
         errors++;
         $display("[TB] FAIL n5_wr_count got %0d expected %0d", wr_obs.size(), wr_exp.size());
      end
      for (int i = 0; i < wr_exp.size() && i < wr_obs.size(); i++) begin
         checks++;
         if (wr_obs[i] !== wr_exp[i]) begin
            errors++;
            $display("[TB] FAIL n5_wr[%0d] got R%0d=%0d expected R%0d=%0d", i,
                     wr_obs[i][33:32], wr_obs[i][31:0], wr_exp[i][33:32], wr_exp[i][31:0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_overflow();
      int   lat;
      bit   to;
      exp_t e;
      for (int n = 12; n <= 13; n++) begin
         start_run(n, 1'b0);
         wait_done(600, lat, to);
         e = sb.pop_front();
         checks++;
         if (to || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL ovf_lat n=%0d got %0d (timeout=%0d) expected %0d", n, lat, to, e.lat);
         end
         checks++;
         if (bus.result !== e.result || bus.overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL ovf_res n=%0d got %h/%b expected %h/%b",
                     n, bus.result, bus.overflow, e.result, e.ovf);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_start_while_busy();
      int   lat;
      bit   to;
      int   extra;
      exp_t e;
      start_run(4, 1'b0);
      repeat (6) @(negedge clk);
      bus.start = 1'b1;
      bus.n_in  = 5'd7;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(600, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat + 7 !== e.lat) begin
         errors++;
         $display("[TB] FAIL busy_lat got %0d (timeout=%0d) expected %0d", lat + 7, to, e.lat);
      end
      checks++;
      if (bus.result !== e.result || bus.overflow !== e.ovf) begin
         errors++;
         $display("[TB] FAIL busy_res got %0d/%b expected %0d/%b", bus.result, bus.overflow, e.result, e.ovf);
      end
      extra = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("[TB] FAIL busy_single_done got %0d extra busy/done cycles expected 0", extra);
      end
      checks++;
      if (bus.result !== 32'd24) begin
         errors++;
         $display("[TB] FAIL busy_result_hold got %0d expected 24", bus.result);
      end
   endtask

   task automatic test_back_to_back();
      int   lat;
      bit   to;
      int   gap;
      exp_t e;
      start_run(2, 1'b1);
      sb.push_back(model(2));
      sb.push_back(model(2));
      wait_done(600, lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat !== e.lat || bus.result !== e.result) begin
         errors++;
         $display("[TB] FAIL b2b_first got lat=%0d result=%0d expected lat=%0d result=%0d",
                  lat, bus.result, e.lat, e.result);
      end
      for (int r = 2; r <= 3; r++) begin
         gap = 0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            gap++;
         end
         if (r == 3) bus.start = 1'b0;
         e = sb.pop_front();
         checks++;
         if (gap != 39) begin
            errors++;
            $display("[TB] FAIL b2b_gap run=%0d got %0d idle cycles between done expected 39", r, gap);
         end
         checks++;
         if (bus.result !== e.result || bus.overflow !== e.ovf) begin
            errors++;
            $display("[TB] FAIL b2b_res run=%0d got %0d/%b expected %0d/%b",
                     r, bus.result, bus.overflow, e.result, e.ovf);
         end
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_stop got busy=%b expected 0", bus.busy);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_reset_mid_run();
      test_small_n();
      test_trace_n5();
      test_overflow();
      test_start_while_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
